alu_mult_sequencer: RTL and testbench

- Multi-cycle controller that reuses the shared execute-stage ALU to compute a 32-bit unsigned multiply, low word only, by iterative shift-and-add.
- Drives the ALU operand/control inputs and captures the ALU output each cycle. Exposes a start/busy/done handshake to the execute-stage control.
- While the sequencer owns the ALU, the pipeline stalls execute on BusyM.

---
 rtl/alu_mult_sequencer.sv | 130 +++++++++++++
 tb/tb_alu_mult_sequencer.sv | 309 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_mult_sequencer.sv
// alu_mult_sequencer: shift-and-add 32-bit multiply (low word) that
// borrows the execute-stage ALU for one add per cycle.
//
// Ports:
//   CLK, RST        clock, async active-low reset
//   StartM          request pulse, accepted only in IDLE
//   OpAM, OpBM      multiplicand / multiplier, captured on accept
//   BusyM           high in RUN and DONE (execute stall request)
//   DoneM           one-cycle pulse, ResultM valid
//   ResultM         product low word, held until next result
//   AluSrcA/B       ALU operands while the sequencer owns the ALU
//   AluControl      ALU function select (always ADD)
//   AluOut          combinational ALU result, same cycle
//
// Build option: define ALU_MULT_EARLY_EXIT_EN to finish as soon as
// the remaining multiplier bits are all zero.

module alu_mult_sequencer #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 6
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             StartM,
  input  logic [WIDTH-1:0] OpAM,
  input  logic [WIDTH-1:0] OpBM,
  output logic             BusyM,
  output logic             DoneM,
  output logic [WIDTH-1:0] ResultM,
  output logic [WIDTH-1:0] AluSrcA,
  output logic [WIDTH-1:0] AluSrcB,
  output logic [2:0]       AluControl,
  input  logic [WIDTH-1:0] AluOut
);

  typedef enum logic [1:0] {
    Idle = 2'd0,
    Run  = 2'd1,
    Done = 2'd2
  } stateT;

  localparam logic [2:0] AluAdd = 3'b010;
  localparam logic [CNT_W-1:0] LastCnt =
    CNT_W'(WIDTH - 1);

  stateT            state;
  logic [WIDTH-1:0] acc;
  logic [WIDTH-1:0] mcand;
  logic [WIDTH-1:0] mplier;
  logic [CNT_W-1:0] cnt;
  logic             earlyExit;
  logic             lastIter;

`ifdef ALU_MULT_EARLY_EXIT_EN
  // No multiplier bits left: the accumulator already holds the product.
  assign earlyExit = (state == Run) && (mplier == '0);
`else
  assign earlyExit = 1'b0;
`endif

  assign lastIter = (cnt == LastCnt);

  // ALU is only driven with live operands in a real RUN iteration;
  // otherwise 0 + 0 keeps the shared ALU output benign.
  always_comb begin
    AluSrcA    = '0;
    AluSrcB    = '0;
    AluControl = AluAdd;
    if (state == Run && !earlyExit) begin
      AluSrcA = acc;
      AluSrcB = mplier[0] ? mcand : '0;
    end
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state   <= Idle;
      acc     <= '0;
      mcand   <= '0;
      mplier  <= '0;
      cnt     <= '0;
      BusyM   <= 1'b0;
      DoneM   <= 1'b0;
      ResultM <= '0;
    end else begin
      unique case (state)
        Idle: begin
          BusyM <= 1'b0;
          DoneM <= 1'b0;
          if (StartM) begin
            acc    <= '0;
            mcand  <= OpAM;
            mplier <= OpBM;
            cnt    <= '0;
            BusyM  <= 1'b1;
            state  <= Run;
          end
        end
        Run: begin
          if (earlyExit) begin
            ResultM <= acc;
            DoneM   <= 1'b1;
            state   <= Done;
          end else begin
            acc    <= AluOut;
            mcand  <= mcand << 1;
            mplier <= mplier >> 1;
            cnt    <= cnt + 1'b1;
            if (lastIter) begin
              ResultM <= AluOut;
              DoneM   <= 1'b1;
              state   <= Done;
            end
          end
        end
        Done: begin
          BusyM <= 1'b0;
          DoneM <= 1'b0;
          state <= Idle;
        end
        default: begin
          BusyM <= 1'b0;
          DoneM <= 1'b0;
          state <= Idle;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_alu_mult_sequencer.sv
// tb_alu_mult_sequencer: directed bench for alu_mult_sequencer
// with a behavioural ALU adder on the shared-ALU ports.

module tb_alu_mult_sequencer;

`ifdef ALU_MULT_EARLY_EXIT_EN
  localparam bit Early = 1'b1;
`else
  localparam bit Early = 1'b0;
`endif

  logic        clk;
  logic        rst;
  logic        startM;
  logic [31:0] opA;
  logic [31:0] opB;
  logic        busy;
  logic        done;
  logic [31:0] result;
  logic [31:0] aluA;
  logic [31:0] aluB;
  logic [2:0]  aluCtl;
  logic [31:0] aluOut;

  int nCmp = 0;
  int nBad = 0;

  alu_mult_sequencer #(.WIDTH(32), .CNT_W(6)) dut (
    .CLK        (clk),
    .RST        (rst),
    .StartM     (startM),
    .OpAM       (opA),
    .OpBM       (opB),
    .BusyM      (busy),
    .DoneM      (done),
    .ResultM    (result),
    .AluSrcA    (aluA),
    .AluSrcB    (aluB),
    .AluControl (aluCtl),
    .AluOut     (aluOut)
  );

  // ALU model: ADD only; any other code yields garbage.
  assign aluOut = (aluCtl == 3'b010) ? aluA + aluB
                                     : 32'hDEAD_BEEF;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Expected start-to-done latency in cycles.
  function automatic int expLat(input logic [31:0] b);
    int h;
    if (!Early) return 33;
    if (b == 0) return 2;
    h = 0;
    for (int i = 0; i < 32; i++)
      if (b[i]) h = i;
    return (h + 3 > 33) ? 33 : h + 3;
  endfunction

  // Pulse StartM across one edge; returns #1 after that edge.
  task automatic startOp(input logic [31:0] a,
                         input logic [31:0] b);
    @(negedge clk);
    startM = 1'b1;
    opA    = a;
    opB    = b;
    @(posedge clk);
    #1;
    startM = 1'b0;
  endtask

  // Runs until BusyM drops; lat = edge of first DoneM + 1.
  task automatic waitDone(output int lat, output int pulses);
    lat    = 0;
    pulses = 0;
    for (int k = 1; k <= 60; k++) begin
      @(posedge clk);
      #1;
      if (done) begin
        pulses++;
        if (lat == 0) lat = k + 1;
      end
      if (!busy) break;
    end
  endtask

  task automatic test_reset;
    rst    = 1'b0;
    startM = 1'b0;
    opA    = '0;
    opB    = '0;
    repeat (3) @(posedge clk);
    #1;
    nCmp++;
    if (busy !== 1'b0) begin
      nBad++;
      $display("FAIL reset_busy: got %b want 0", busy);
    end
    nCmp++;
    if (done !== 1'b0) begin
      nBad++;
      $display("FAIL reset_done: got %b want 0", done);
    end
    nCmp++;
    if (result !== 32'd0) begin
      nBad++;
      $display("FAIL reset_result: got %h want 0", result);
    end
    nCmp++;
    if ({aluA, aluB} !== 64'd0 || aluCtl !== 3'b010) begin
      nBad++;
      $display("FAIL reset_alu: got %h %h %b want 0 0 010",
               aluA, aluB, aluCtl);
    end
    @(negedge clk);
    rst = 1'b1;
  endtask

  task automatic test_multiply;
    int lat, pulses;
    startOp(32'd7, 32'd6);
    nCmp++;
    if (busy !== 1'b1) begin
      nBad++;
      $display("FAIL mul_busy_next: got %b want 1", busy);
    end
    waitDone(lat, pulses);
    nCmp++;
    if (lat !== expLat(32'd6)) begin
      nBad++;
      $display("FAIL mul_latency: got %0d want %0d",
               lat, expLat(32'd6));
    end
    nCmp++;
    if (pulses !== 1) begin
      nBad++;
      $display("FAIL mul_pulses: got %0d want 1", pulses);
    end
    repeat (3) @(posedge clk);
    #1;
    nCmp++;
    if (result !== 32'd42) begin
      nBad++;
      $display("FAIL mul_result_held: got %0d want 42", result);
    end
  endtask

  task automatic test_wrap;
    int lat, pulses;
    startOp(32'hFFFF_FFFF, 32'hFFFF_FFFF);
    waitDone(lat, pulses);
    nCmp++;
    if (result !== 32'h0000_0001 || lat !== 33) begin
      nBad++;
      $display("FAIL wrap_ones: got %h lat %0d want 1 lat 33",
               result, lat);
    end
    startOp(32'h8000_0000, 32'd2);
    waitDone(lat, pulses);
    nCmp++;
    if (result !== 32'd0 || lat !== expLat(32'd2)) begin
      nBad++;
      $display("FAIL wrap_msb: got %h lat %0d want 0 lat %0d",
               result, lat, expLat(32'd2));
    end
  endtask

  task automatic test_start_busy;
    int lat, pulses;
    startOp(32'd7, 32'd6);
    if (!Early) repeat (8) @(posedge clk);
    startOp(32'd3, 32'd3);
    waitDone(lat, pulses);
    nCmp++;
    if (result !== 32'd42) begin
      nBad++;
      $display("FAIL busy_start_result: got %0d want 42", result);
    end
    nCmp++;
    if (pulses !== 1) begin
      nBad++;
      $display("FAIL busy_start_pulses: got %0d want 1", pulses);
    end
    repeat (4) @(posedge clk);
    #1;
    nCmp++;
    if (busy !== 1'b0 || done !== 1'b0) begin
      nBad++;
      $display("FAIL busy_start_queued: got busy %b done %b want 0 0",
               busy, done);
    end
  endtask

  task automatic test_alu_drive;
    logic [31:0] expA, expB;
    logic [31:0] b;
    b = 32'hA;
    @(posedge clk);
    #1;
    nCmp++;
    if ({aluA, aluB} !== 64'd0 || aluCtl !== 3'b010) begin
      nBad++;
      $display("FAIL alu_idle: got %h %h %b want 0 0 010",
               aluA, aluB, aluCtl);
    end
    startOp(32'd5, b);
    // Iterations 0..3 of 5 * 0b1010.
    for (int i = 0; i < 4; i++) begin
      expA = 32'd5 * (b & ((32'd1 << i) - 32'd1));
      expB = b[i] ? (32'd5 << i) : 32'd0;
      nCmp++;
      if (aluA !== expA || aluB !== expB || aluCtl !== 3'b010) begin
        nBad++;
        $display("FAIL alu_run_%0d: got %h %h %b want %h %h 010",
                 i, aluA, aluB, aluCtl, expA, expB);
      end
      @(posedge clk);
      #1;
    end
    for (int k = 0; k < 60; k++) begin
      if (done) break;
      @(posedge clk);
      #1;
    end
    nCmp++;
    if (done !== 1'b1 || {aluA, aluB} !== 64'd0 ||
        result !== 32'd50) begin
      nBad++;
      $display("FAIL alu_done: got done %b %h %h res %0d want 1 0 0 50",
               done, aluA, aluB, result);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset_mid;
    int lat, pulses;
    startOp(32'd7, 32'd6);
    if (!Early) repeat (14) @(posedge clk);
    else repeat (2) @(posedge clk);
    #2;
    rst = 1'b0;
    #1;
    nCmp++;
    if (busy !== 1'b0 || done !== 1'b0 || result !== 32'd0) begin
      nBad++;
      $display("FAIL rst_mid_now: got %b %b %h want 0 0 0",
               busy, done, result);
    end
    repeat (2) @(posedge clk);
    #1;
    nCmp++;
    if (done !== 1'b0 || aluA !== 32'd0) begin
      nBad++;
      $display("FAIL rst_mid_hold: got done %b aluA %h want 0 0",
               done, aluA);
    end
    @(negedge clk);
    rst = 1'b1;
    startOp(32'd5, 32'd5);
    waitDone(lat, pulses);
    nCmp++;
    if (result !== 32'd25 || lat !== expLat(32'd5)) begin
      nBad++;
      $display("FAIL rst_mid_after: got %0d lat %0d want 25 lat %0d",
               result, lat, expLat(32'd5));
    end
  endtask

  task automatic test_early_exit;
    int lat, pulses;
    startOp(32'd5, 32'd1);
    waitDone(lat, pulses);
    nCmp++;
    if (result !== 32'd5 || lat !== (Early ? 3 : 33)) begin
      nBad++;
      $display("FAIL early_one: got %0d lat %0d want 5 lat %0d",
               result, lat, Early ? 3 : 33);
    end
    startOp(32'd9, 32'd0);
    waitDone(lat, pulses);
    nCmp++;
    if (result !== 32'd0 || lat !== (Early ? 2 : 33)) begin
      nBad++;
      $display("FAIL early_zero: got %0d lat %0d want 0 lat %0d",
               result, lat, Early ? 2 : 33);
    end
    nCmp++;
    if (pulses !== 1) begin
      nBad++;
      $display("FAIL early_pulses: got %0d want 1", pulses);
    end
  endtask

  initial begin
    test_reset;
    test_multiply;
    test_wrap;
    test_start_busy;
    test_alu_drive;
    test_reset_mid;
    test_early_exit;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             nCmp, nBad);
    $finish;
  end

endmodule
